spi_sram_slave_ng: RTL



---
 rtl/spi_sram_pkg.sv | 30 +++
 rtl/spi_bit_counter.sv | 27 ++
 rtl/spi_sram_slave_ng.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_sram_pkg.sv
// Shared types and constants for the SPI SRAM slave.
package spi_sram_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_RD,
    ST_WR,
    ST_RD_MODE,
    ST_WR_MODE,
    ST_ERR,
    ST_DONE
  } state_t;

  localparam logic [7:0] CMD_READ      = 8'h03;
  localparam logic [7:0] CMD_FAST_READ = 8'h0B;
  localparam logic [7:0] CMD_WRITE     = 8'h02;
  localparam logic [7:0] CMD_RDMR      = 8'h05;
  localparam logic [7:0] CMD_WRMR      = 8'h01;

  localparam logic [1:0] MODE_BYTE = 2'b00;
  localparam logic [1:0] MODE_PAGE = 2'b10;
  localparam logic [1:0] MODE_SEQ  = 2'b01;

  // Wide enough for the longest field: a 32-bit address or the CS delay.
  localparam int CNT_W = 6;

endpackage

// File: rtl/spi_bit_counter.sv
// Loadable bit down-counter; tc flags the last bit of the current field.
module spi_bit_counter
  import spi_sram_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  // Load wins over decrement; count holds at zero until reloaded.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/spi_sram_slave_ng.sv
// SPI mode-0 SRAM slave: command/address decode, byte/page/sequential access.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | deselected, waiting for cs_n low on en
// ST_CMD     | shifting in the 8-bit opcode
// ST_ADDR    | shifting in the address
// ST_DUMMY   | FAST_READ dummy cycles, mosi ignored
// ST_RD      | streaming read data on en_fall, prefetching next byte
// ST_WR      | collecting write bytes, one SRAM write per byte
// ST_RD_MODE | shifting out {mode,6'b0} repeatedly
// ST_WR_MODE | first byte sets mode, later bytes ignored
// ST_ERR     | unknown opcode or early reselect, wait for deselect
// ST_DONE    | deselect guard time before the next command
module spi_sram_slave_ng
  import spi_sram_pkg::*;
#(
  parameter int         ADDR_BYTES = 3,
  parameter int         PAGE_BYTES = 32,
  parameter int         CS_DELAY   = 3,
  parameter int         DUMMY_BITS = 8,
  parameter logic [1:0] MODE_RESET = 2'b01,
  localparam int        ADDR_W     = 8 * ADDR_BYTES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              en_fall,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic [1:0]        mode
);

  localparam int                SR_W      = ADDR_W - 1;
  localparam logic [ADDR_W-1:0] PAGE_MASK = ADDR_W'(PAGE_BYTES - 1);
  localparam logic [CNT_W-1:0]  CNT_BYTE  = CNT_W'(7);
  localparam logic [CNT_W-1:0]  CNT_CMD   = CNT_W'(6);
  localparam logic [CNT_W-1:0]  CNT_ADDR  = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0]  CNT_DUMMY = CNT_W'(DUMMY_BITS - 1);
  localparam logic [CNT_W-1:0]  CNT_DELAY = (CS_DELAY > 0) ? CNT_W'(CS_DELAY - 1) : '0;

  state_t            state;
  logic [SR_W-1:0]   sr;
  logic [ADDR_W-1:0] cur_addr;
  logic [7:0]        op;
  logic [7:0]        tx_sr;
  logic [7:0]        rbuf;
  logic              fetch_d1;
  logic              byte_done;

  logic              cnt_load;
  logic [CNT_W-1:0]  cnt_val;
  logic [CNT_W-1:0]  cnt;
  logic              tc;

  logic [7:0]        rx_byte;
  logic [ADDR_W-1:0] addr_full;
  logic [7:0]        rd_byte;
  logic              deselect;
  logic              is_mode_cmd;

  // The byte currently completing on this en includes the live mosi bit.
  assign rx_byte     = {sr[6:0], mosi};
  assign addr_full   = {sr, mosi};
  // Bypass the capture register when the SRAM answer is still on the bus.
  assign rd_byte     = fetch_d1 ? mem_rdata : rbuf;
  assign deselect    = cs_n && (state != ST_IDLE) && (state != ST_DONE);
  assign is_mode_cmd = (rx_byte == CMD_RDMR) || (rx_byte == CMD_WRMR);

  function automatic logic [ADDR_W-1:0] inc_addr(input logic [ADDR_W-1:0] a,
                                                 input logic [1:0]        m);
    logic [ADDR_W-1:0] p;
    p = a + ADDR_W'(1);
    if (m == MODE_PAGE) return (a & ~PAGE_MASK) | (p & PAGE_MASK);
    return p;
  endfunction

  // Pick the length of the next field whenever the current one ends.
  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = CNT_BYTE;
    if (deselect) begin
      cnt_load = 1'b1;
      cnt_val  = CNT_DELAY;
    end else if (en) begin
      unique case (state)
        ST_IDLE: if (!cs_n) begin
          cnt_load = 1'b1;
          cnt_val  = CNT_CMD;
        end
        ST_CMD: if (tc) begin
          cnt_load = 1'b1;
          cnt_val  = is_mode_cmd ? CNT_BYTE : CNT_ADDR;
        end
        ST_ADDR: if (tc) begin
          cnt_load = 1'b1;
          cnt_val  = (op == CMD_FAST_READ) ? CNT_DUMMY : CNT_BYTE;
        end
        ST_DUMMY, ST_RD, ST_WR, ST_RD_MODE, ST_WR_MODE: if (tc) cnt_load = 1'b1;
        default: ;
      endcase
    end
  end

  spi_bit_counter u_bit_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (en),
    .count    (cnt),
    .tc       (tc)
  );

  // Protocol FSM with registered SRAM and serial outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      mode      <= MODE_RESET;
      miso      <= 1'b0;
      miso_oe   <= 1'b0;
      mem_en    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      sr        <= '0;
      cur_addr  <= '0;
      op        <= '0;
      tx_sr     <= '0;
      rbuf      <= '0;
      fetch_d1  <= 1'b0;
      byte_done <= 1'b0;
    end else begin
      mem_en   <= 1'b0;
      mem_wr   <= 1'b0;
      fetch_d1 <= mem_en && !mem_wr;
      if (fetch_d1) rbuf <= mem_rdata;

      if (deselect) begin
        // Partial bytes are dropped; a write already on the bus still completes.
        state     <= (CS_DELAY == 0) ? ST_IDLE : ST_DONE;
        miso      <= 1'b0;
        miso_oe   <= 1'b0;
        byte_done <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE: if (en && !cs_n) begin
            sr        <= {sr[SR_W-2:0], mosi};
            byte_done <= 1'b0;
            state     <= ST_CMD;
          end
          ST_CMD: if (en) begin
            sr <= {sr[SR_W-2:0], mosi};
            if (tc) begin
              op <= rx_byte;
              unique case (rx_byte)
                CMD_READ, CMD_FAST_READ, CMD_WRITE: state <= ST_ADDR;
                CMD_RDMR: state <= ST_RD_MODE;
                CMD_WRMR: state <= ST_WR_MODE;
                default:  state <= ST_ERR;
              endcase
            end
          end
          ST_ADDR: if (en) begin
            sr <= {sr[SR_W-2:0], mosi};
            if (tc) begin
              cur_addr <= addr_full;
              if (op == CMD_FAST_READ) begin
                state <= ST_DUMMY;
              end else if (op == CMD_READ) begin
                state    <= ST_RD;
                mem_en   <= 1'b1;
                mem_addr <= addr_full;
                cur_addr <= inc_addr(addr_full, mode);
              end else begin
                state <= ST_WR;
              end
            end
          end
          ST_DUMMY: if (en && tc) begin
            state    <= ST_RD;
            mem_en   <= 1'b1;
            mem_addr <= cur_addr;
            cur_addr <= inc_addr(cur_addr, mode);
          end
          ST_RD: begin
            if (en) begin
              // Prefetch on bit 1 so the next byte is ready for its first en_fall.
              if ((cnt == CNT_W'(1)) && (mode != MODE_BYTE)) begin
                mem_en   <= 1'b1;
                mem_addr <= cur_addr;
                cur_addr <= inc_addr(cur_addr, mode);
              end
              if (tc && (mode == MODE_BYTE)) byte_done <= 1'b1;
            end
            if (en_fall) begin
              if (byte_done) begin
                miso    <= 1'b0;
                miso_oe <= 1'b0;
              end else if (cnt == CNT_BYTE) begin
                miso    <= rd_byte[7];
                tx_sr   <= {rd_byte[6:0], 1'b0};
                miso_oe <= 1'b1;
              end else begin
                miso  <= tx_sr[7];
                tx_sr <= {tx_sr[6:0], 1'b0};
              end
            end
          end
          ST_RD_MODE: if (en_fall) begin
            miso_oe <= 1'b1;
            if (cnt == CNT_BYTE) begin
              miso  <= mode[1];
              tx_sr <= {mode[0], 7'b0};
            end else begin
              miso  <= tx_sr[7];
              tx_sr <= {tx_sr[6:0], 1'b0};
            end
          end
          ST_WR: if (en) begin
            sr <= {sr[SR_W-2:0], mosi};
            if (tc && !byte_done) begin
              mem_en    <= 1'b1;
              mem_wr    <= 1'b1;
              mem_addr  <= cur_addr;
              mem_wdata <= rx_byte;
              cur_addr  <= inc_addr(cur_addr, mode);
              if (mode == MODE_BYTE) byte_done <= 1'b1;
            end
          end
          ST_WR_MODE: if (en) begin
            sr <= {sr[SR_W-2:0], mosi};
            if (tc && !byte_done) begin
              mode      <= sr[6:5];
              byte_done <= 1'b1;
            end
          end
          ST_ERR: ;
          ST_DONE: if (en) begin
            if (!cs_n)   state <= ST_ERR;
            else if (tc) state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
